// File: rtl/la_ioinput_ctrl.sv
// la_ioinput_ctrl: staggered ie sequencer, per-pad cfg registers and z synchronizers
// for a bank of N input pads. Define LA_IOINPUT_FILTER_EN to add a per-pad glitch filter on din.

module la_ioinput_ctrl #(
  parameter int              N         = 4,
  parameter int              CFGW      = 16,
  parameter logic [CFGW-1:0] CFG_RESET = '0,
  parameter int              STAGGER   = 8,
  parameter int              FILT      = 4,
  localparam int             AW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CFGW-1:0]   wr_data,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      ie,
  output logic [N*CFGW-1:0] cfg,
  input  logic [N-1:0]      z,
  output logic [N-1:0]      din
);

  localparam int IW = $clog2(N) + 1;
  localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [SW-1:0] STG_LAST = SW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(N - 1);
  localparam logic [IW-1:0] IDX_DIS0 = (N > 1) ? IW'(N - 2) : IW'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENABLE  = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DISABLE = 2'd3
  } state_t;

  if (N < 1 || N > 32 || STAGGER < 1 || FILT < 2) begin : g_bad_param
    $error("la_ioinput_ctrl: parameter out of range");
  end

  state_t              state_r;
  state_t              state_s;
  logic [N-1:0]        ie_r;
  logic [N-1:0]        ie_s;
  logic [IW-1:0]       idx_r;
  logic [IW-1:0]       idx_s;
  logic [SW-1:0]       stg_r;
  logic [SW-1:0]       stg_s;
  logic                busy_r;
  logic                done_r;
  logic                wr_ready_r;
  logic                wr_en_s;
  logic [N*CFGW-1:0]   cfg_r;
  logic [N-1:0]        sync1_r;
  logic [N-1:0]        sync2_r;

  function automatic logic [N-1:0] pad_mask(input logic [IW-1:0] idx);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) begin
      m[i] = (idx == IW'(i));
    end
    return m;
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state: leave ENABLE/DISABLE once the last pad of the ramp has switched
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_ENABLE;
        else       state_s = ST_IDLE;
      end
      ST_ENABLE: begin
        if (ie_r[N-1]) state_s = ST_ACTIVE;
        else           state_s = ST_ENABLE;
      end
      ST_ACTIVE: begin
        if (stop) state_s = ST_DISABLE;
        else      state_s = ST_ACTIVE;
      end
      ST_DISABLE: begin
        if (!ie_r[0]) state_s = ST_IDLE;
        else          state_s = ST_DISABLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // ramp datapath: idx is the next pad to switch, stg counts cycles between switches
  always_comb begin
    ie_s  = ie_r;
    idx_s = idx_r;
    stg_s = stg_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          ie_s  = pad_mask(IW'(0));
          idx_s = IW'(1);
          stg_s = '0;
        end else begin
          stg_s = '0;
        end
      end
      ST_ENABLE: begin
        if (ie_r[N-1]) begin
          stg_s = '0;
        end else if (stg_r == STG_LAST) begin
          ie_s  = ie_r | pad_mask(idx_r);
          idx_s = idx_r + IW'(1);
          stg_s = '0;
        end else begin
          stg_s = stg_r + SW'(1);
        end
      end
      ST_ACTIVE: begin
        if (stop) begin
          ie_s  = ie_r & ~pad_mask(IDX_TOP);
          idx_s = IDX_DIS0;
          stg_s = '0;
        end else begin
          stg_s = '0;
        end
      end
      ST_DISABLE: begin
        if (!ie_r[0]) begin
          stg_s = '0;
        end else if (stg_r == STG_LAST) begin
          ie_s  = ie_r & ~pad_mask(idx_r);
          idx_s = idx_r - IW'(1);
          stg_s = '0;
        end else begin
          stg_s = stg_r + SW'(1);
        end
      end
      default: begin
        ie_s  = '0;
        idx_s = '0;
        stg_s = '0;
      end
    endcase
  end

  // ramp registers and status flags, all derived from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_r       <= '0;
      idx_r      <= '0;
      stg_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      wr_ready_r <= 1'b1;
    end else begin
      ie_r       <= ie_s;
      idx_r      <= idx_s;
      stg_r      <= stg_s;
      busy_r     <= (state_s == ST_ENABLE) || (state_s == ST_DISABLE);
      done_r     <= (state_s == ST_ACTIVE);
      wr_ready_r <= (state_s == ST_IDLE) || (state_s == ST_ACTIVE);
    end
  end

  assign wr_en_s = wr_valid & wr_ready_r;

  // cfg registers; an out-of-range address matches no pad and is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_r <= {N{CFG_RESET}};
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_en_s && (wr_addr == AW'(i))) begin
          cfg_r[i*CFGW +: CFGW] <= wr_data;
        end
      end
    end
  end

  // two-flop synchronizer, gated by the upcoming ie so din is 0 whenever ie is 0
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= z & ie_s;
      sync2_r <= sync1_r & ie_s;
    end
  end

`ifdef LA_IOINPUT_FILTER_EN
  localparam int FW = $clog2(FILT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);

  logic [FW-1:0] fcnt_r [N];
  logic [N-1:0]  din_r;

  // glitch filter: din flips on the FILT-th consecutive differing sample
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        fcnt_r[i] <= '0;
      end
      din_r <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!ie_s[i]) begin
          fcnt_r[i] <= '0;
          din_r[i]  <= 1'b0;
        end else if (sync2_r[i] != din_r[i]) begin
          if (fcnt_r[i] == FILT_LAST) begin
            fcnt_r[i] <= '0;
            din_r[i]  <= sync2_r[i];
          end else begin
            fcnt_r[i] <= fcnt_r[i] + FW'(1);
          end
        end else begin
          fcnt_r[i] <= '0;
        end
      end
    end
  end

  assign din = din_r;
`else
  assign din = sync2_r;
`endif

  assign ie       = ie_r;
  assign cfg      = cfg_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign wr_ready = wr_ready_r;

endmodule

// File: tb/tb_la_ioinput_ctrl.sv
// Self-checking bench for la_ioinput_ctrl: randomized stimulus against a timing-rule reference model.
`timescale 1ns/1ps

module tb_la_ioinput_ctrl;

  localparam int N       = 4;
  localparam int CFGW    = 16;
  localparam int STAGGER = 8;
  localparam int FILT    = 4;
  localparam int AW      = 2;
  localparam logic [CFGW-1:0] CFG_RESET = 16'h0C3A;
  localparam int SEQ     = 2 + (N - 1) * STAGGER;
`ifdef LA_IOINPUT_FILTER_EN
  localparam int LAT = 2 + FILT;
`else
  localparam int LAT = 2;
`endif
  localparam int P_IDLE = 0, P_EN = 1, P_ACT = 2, P_DIS = 3;

  logic              clk = 1'b0;
  logic              reset, start, stop, wr_valid;
  logic              wr_ready, busy, done;
  logic [AW-1:0]     wr_addr;
  logic [CFGW-1:0]   wr_data;
  logic [N-1:0]      ie, z, din;
  logic [N*CFGW-1:0] cfg;

  int checks = 0;
  int errors = 0;
  int ph = P_IDLE;
  int k  = 0;
  logic [CFGW-1:0] cfg_m [N];

  la_ioinput_ctrl #(
    .N(N), .CFGW(CFGW), .CFG_RESET(CFG_RESET), .STAGGER(STAGGER), .FILT(FILT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .ie(ie), .cfg(cfg), .z(z), .din(din)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // pad i is on k>=1+i*STAGGER cycles into the ramp-up; pad i is off k>=1+(N-1-i)*STAGGER into ramp-down
  function automatic logic [N-1:0] exp_ie();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      case (ph)
        P_EN:    v[i] = (k >= 1 + i * STAGGER);
        P_ACT:   v[i] = 1'b1;
        P_DIS:   v[i] = (k < 1 + (N - 1 - i) * STAGGER);
        default: v[i] = 1'b0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [N*CFGW-1:0] exp_cfg();
    logic [N*CFGW-1:0] v;
    for (int i = 0; i < N; i++) v[i*CFGW +: CFGW] = cfg_m[i];
    return v;
  endfunction

  // advance the reference model with the inputs now applied, then clock once
  task automatic step();
    if (reset) begin
      ph = P_IDLE;
      k  = 0;
      for (int i = 0; i < N; i++) cfg_m[i] = CFG_RESET;
    end else begin
      if (wr_valid && (ph == P_IDLE || ph == P_ACT) && int'(wr_addr) < N) cfg_m[wr_addr] = wr_data;
      case (ph)
        P_IDLE: if (start) begin ph = P_EN; k = 1; end
        P_EN:   begin k++; if (k >= SEQ) ph = P_ACT; end
        P_ACT:  if (stop) begin ph = P_DIS; k = 1; end
        P_DIS:  begin k++; if (k >= SEQ) ph = P_IDLE; end
        default: ph = P_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_wr();
    wr_valid = 1'($urandom_range(0, 1));
    wr_addr  = AW'($urandom);
    wr_data  = CFGW'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (ie !== 4'b0000)  begin errors++; $display("FAIL reset_ie: got %b, expected 0000", ie); end
    checks++; if (din !== 4'b0000) begin errors++; $display("FAIL reset_din: got %b, expected 0000", din); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_status: busy=%b done=%b, expected 0 0", busy, done); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b, expected 1", wr_ready); end
    checks++; if (cfg !== {N{CFG_RESET}}) begin errors++; $display("FAIL reset_cfg: got %h, expected %h", cfg, {N{CFG_RESET}}); end
    reset = 1'b0;
  endtask

  task automatic test_cfg_idle();
    wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 16'hA5A5;
    step();
    checks++; if (cfg[47:32] !== 16'hA5A5) begin errors++; $display("FAIL cfg_pad2: got %h, expected a5a5", cfg[47:32]); end
    for (int n = 0; n < 8; n++) begin
      rand_wr();
      step();
      checks++; if (cfg !== exp_cfg()) begin errors++; $display("FAIL cfg_idle_rand: got %h, expected %h", cfg, exp_cfg()); end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_enable();
    for (int n = 0; n < 4 * SEQ; n++) begin
      if (n == 0) begin start = 1'b1; stop = 1'b1; end
      else begin start = 1'($urandom_range(0, 1)); stop = 1'($urandom_range(0, 1)); end
      if (n == 3) begin wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 16'h5A5A; end
      else rand_wr();
      step();
      checks++; if (ie !== exp_ie()) begin errors++; $display("FAIL enable_ie k=%0d: got %b, expected %b", k, ie, exp_ie()); end
      checks++; if (busy !== (ph == P_EN) || done !== (ph == P_ACT)) begin errors++; $display("FAIL enable_status k=%0d: busy=%b done=%b", k, busy, done); end
      checks++; if (wr_ready !== (ph == P_ACT)) begin errors++; $display("FAIL enable_wr_ready k=%0d: got %b", k, wr_ready); end
      checks++; if (cfg !== exp_cfg()) begin errors++; $display("FAIL enable_cfg k=%0d: got %h, expected %h", k, cfg, exp_cfg()); end
      if (k == 1)  begin checks++; if (ie !== 4'b0001) begin errors++; $display("FAIL enable_t1: got %b, expected 0001", ie); end end
      if (k == 17) begin checks++; if (ie !== 4'b0111) begin errors++; $display("FAIL enable_t17: got %b, expected 0111", ie); end end
      if (k == 25) begin checks++; if (ie !== 4'b1111 || done !== 1'b0) begin errors++; $display("FAIL enable_t25: ie=%b done=%b, expected 1111 0", ie, done); end end
      if (k == SEQ) begin checks++; if (done !== 1'b1) begin errors++; $display("FAIL enable_done: got %b, expected 1", done); end end
      if (ph != P_EN) break;
    end
    checks++; if (ph != P_ACT) begin errors++; $display("FAIL enable_timeout: phase %0d, expected active", ph); end
    start = 1'b0; stop = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic test_start_active();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (ie !== 4'b1111 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL start_active: ie=%b done=%b busy=%b, expected 1111 1 0", ie, done, busy); end
  endtask

  task automatic test_din();
    logic [N-1:0] zprev = '0;
    logic [N-1:0] ycur;
    logic [N-1:0] expd;
`ifdef LA_IOINPUT_FILTER_EN
    logic [N-1:0] yold = '0;
    logic [N-1:0] dm = '0;
    logic [N-1:0] yq [$];
    logic all_diff;
`endif
    for (int s = 0; s < 120; s++) begin
      if (s < 80)       z = N'($urandom);
      else if (s < 100) z = 4'b0000;
      else if (s < 103) z = 4'b0010;
      else if (s < 110) z = 4'b0000;
      else              z = 4'b0010;
      rand_wr();
      start = 1'($urandom_range(0, 1));
      step();
      ycur  = zprev;
      zprev = z;
`ifdef LA_IOINPUT_FILTER_EN
      yq.push_back(yold);
      yold = ycur;
      for (int p = 0; p < N; p++) begin
        if (yq.size() >= FILT) begin
          all_diff = 1'b1;
          for (int f = 0; f < FILT; f++) if (yq[yq.size() - 1 - f][p] == dm[p]) all_diff = 1'b0;
          if (all_diff) dm[p] = ~dm[p];
        end
      end
      expd = dm;
      if (s >= 100 && s < 110) begin checks++; if (din[1] !== 1'b0) begin errors++; $display("FAIL din_pulse s=%0d: got %b, expected 0", s, din[1]); end end
`else
      expd = ycur;
`endif
      checks++; if (din !== expd) begin errors++; $display("FAIL din_model s=%0d: got %b, expected %b", s, din, expd); end
      checks++; if (cfg !== exp_cfg()) begin errors++; $display("FAIL active_cfg s=%0d: got %h, expected %h", s, cfg, exp_cfg()); end
      if (s == 110 + LAT - 2) begin checks++; if (din[1] !== 1'b0) begin errors++; $display("FAIL din_early: got %b, expected 0", din[1]); end end
      if (s == 110 + LAT - 1) begin checks++; if (din[1] !== 1'b1) begin errors++; $display("FAIL din_latency: got %b, expected 1", din[1]); end end
    end
    checks++; if (ie !== 4'b1111 || done !== 1'b1) begin errors++; $display("FAIL din_active: ie=%b done=%b", ie, done); end
    start = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic test_disable();
    for (int n = 0; n < 4 * SEQ; n++) begin
      if (n == 0) begin start = 1'b1; stop = 1'b1; end
      else begin start = 1'($urandom_range(0, 1)); stop = 1'($urandom_range(0, 1)); end
      z = N'($urandom);
      rand_wr();
      step();
      checks++; if (ie !== exp_ie()) begin errors++; $display("FAIL disable_ie k=%0d: got %b, expected %b", k, ie, exp_ie()); end
      checks++; if (busy !== (ph == P_DIS) || done !== 1'b0) begin errors++; $display("FAIL disable_status k=%0d: busy=%b done=%b", k, busy, done); end
      checks++; if (wr_ready !== (ph == P_IDLE)) begin errors++; $display("FAIL disable_wr_ready k=%0d: got %b", k, wr_ready); end
      checks++; if (cfg !== exp_cfg()) begin errors++; $display("FAIL disable_cfg k=%0d: got %h, expected %h", k, cfg, exp_cfg()); end
      checks++; if ((din & ~exp_ie()) !== 4'b0000) begin errors++; $display("FAIL disable_din k=%0d: din=%b ie=%b", k, din, exp_ie()); end
      if (k == 1)  begin checks++; if (ie !== 4'b0111) begin errors++; $display("FAIL disable_t1: got %b, expected 0111", ie); end end
      if (k == 25) begin checks++; if (ie !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL disable_t25: ie=%b busy=%b, expected 0000 1", ie, busy); end end
      if (k == SEQ) begin checks++; if (wr_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL disable_idle: wr_ready=%b busy=%b, expected 1 0", wr_ready, busy); end end
      if (ph != P_DIS) break;
    end
    checks++; if (ph != P_IDLE) begin errors++; $display("FAIL disable_timeout: phase %0d, expected idle", ph); end
    start = 1'b0; stop = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; stop = 1'b1;
    for (int n = 0; n < 3 * SEQ + 10; n++) begin
      z = N'($urandom);
      rand_wr();
      step();
      checks++; if (ie !== exp_ie()) begin errors++; $display("FAIL b2b_ie n=%0d: got %b, expected %b", n, ie, exp_ie()); end
      checks++; if (done !== (ph == P_ACT) || wr_ready !== (ph == P_IDLE || ph == P_ACT)) begin errors++; $display("FAIL b2b_status n=%0d: done=%b wr_ready=%b", n, done, wr_ready); end
      checks++; if (cfg !== exp_cfg()) begin errors++; $display("FAIL b2b_cfg n=%0d: got %h, expected %h", n, cfg, exp_cfg()); end
      checks++; if ((din & ~exp_ie()) !== 4'b0000) begin errors++; $display("FAIL b2b_din n=%0d: din=%b ie=%b", n, din, exp_ie()); end
    end
    start = 1'b0; stop = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    step();
    reset = 1'b0;
    z = 4'b1111;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 11; n++) step();
    checks++; if (ie !== exp_ie() || k != 12) begin errors++; $display("FAIL mid_pre: got %b, expected %b", ie, exp_ie()); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (ie !== 4'b0000 || din !== 4'b0000) begin errors++; $display("FAIL mid_reset: ie=%b din=%b, expected 0000 0000", ie, din); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL mid_status: busy=%b done=%b wr_ready=%b, expected 0 0 1", busy, done, wr_ready); end
    checks++; if (cfg !== {N{CFG_RESET}}) begin errors++; $display("FAIL mid_cfg: got %h, expected %h", cfg, {N{CFG_RESET}}); end
    for (int n = 0; n < 3; n++) begin
      step();
      checks++; if (ie !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL mid_idle: ie=%b busy=%b", ie, busy); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; z = '0;
    for (int i = 0; i < N; i++) cfg_m[i] = CFG_RESET;
    test_reset();
    test_cfg_idle();
    test_enable();
    test_start_active();
    test_din();
    test_disable();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
